sub_32_seq: RTL

SUB_32_SEQ -- requirements
Module: sub_32_seq

---
 rtl/sub_pkg.sv | 15 +
 rtl/adder_8.sv | 17 +
 rtl/sub_32_seq.sv | 91 +++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared constants and FSM state encoding for the
// slice-serial 32-bit subtractor.
package sub_pkg;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/adder_8.sv
// 8-bit ripple adder.
// Ports: a, b, cin -> s, cout.
module adder_8
  import sub_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);

  always_comb begin
    {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  end

endmodule

// File: rtl/sub_32_seq.sv
// Slice-serial 32-bit subtractor: in1 - in2 - bin, one
// 8-bit slice per clock, LSB first, single shared adder.
// Ports: clk, rst_n, start, in1, in2, bin -> busy, done, diff, bout.
module sub_32_seq
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam logic [1:0] LAST = 2'(NSLICE - 1);

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] s_d;
  logic             c_d;
  int               idx;

  always_comb begin
    idx = int'(cnt_q) * SLICE;
    a_s = a_q[idx +: SLICE];
    // subtraction as addition of the inverted subtrahend
    b_s = ~b_q[idx +: SLICE];
  end

  adder_8 u_add (
    .a    (a_s),
    .b    (b_s),
    .cin  (c_q),
    .s    (s_d),
    .cout (c_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            a_q     <= in1;
            b_q     <= in2;
            c_q     <= ~bin;
          end else begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          diff_q[idx +: SLICE] <= s_d;
          c_q                  <= c_d;
          cnt_q                <= cnt_q + 2'd1;
          if (cnt_q == LAST) begin
            bout_q  <= ~c_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
